// File: rtl/tcp_slow_pkg.sv
// Shared constants and types for the TCP RX slow-path flow lifecycle controller.
package tcp_slow_pkg;

    localparam logic [7:0] FLAG_FIN = 8'h01;
    localparam logic [7:0] FLAG_SYN = 8'h02;
    localparam logic [7:0] FLAG_RST = 8'h04;

    typedef enum logic [1:0] {
        RSN_OK        = 2'd0,
        RSN_BAD_PKT   = 2'd1,
        RSN_NO_FLOWID = 2'd2,
        RSN_TIMEOUT   = 2'd3
    } reason_e;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_ALLOC = 3'd1;
    localparam logic [ST_W-1:0] ST_INIT  = 3'd2;
    localparam logic [ST_W-1:0] ST_SEND  = 3'd3;
    localparam logic [ST_W-1:0] ST_NOTIF = 3'd4;
    localparam logic [ST_W-1:0] ST_FREE  = 3'd5;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd6;

    // FIN or RST requests teardown of an existing flow
    function automatic logic is_close_flags(input logic [7:0] flags);
        return (flags & (FLAG_FIN | FLAG_RST)) != 8'h00;
    endfunction

endpackage

// File: rtl/tcp_slow_hs_timer.sv
// Per-state wait counter: loaded on state entry, expires on the last permitted cycle.
module tcp_slow_hs_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/tcp_rx_flow_lifecycle_ctrl.sv
// Slow-path controller: opens flows on SYN, tears them down on FIN/RST, with bounded waits and stats.
module tcp_rx_flow_lifecycle_ctrl
    import tcp_slow_pkg::*;
#(
    parameter int unsigned FLOWID_W    = 8,
    parameter int unsigned FLOWID_WAIT = 4,
    parameter int unsigned HS_TIMEOUT  = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                slow_path_val,
    output logic                slow_path_rdy,
    input  logic [7:0]          slow_path_flags,
    input  logic                slow_path_lookup_hit,
    input  logic [FLOWID_W-1:0] slow_path_lookup_flowid,
    output logic                flowid_alloc_val,
    input  logic                flowid_alloc_rdy,
    input  logic [FLOWID_W-1:0] flowid_alloc_id,
    output logic                flowid_free_val,
    input  logic                flowid_free_rdy,
    output logic                init_state_val,
    input  logic                init_state_rdy,
    output logic                send_pkt_enqueue_val,
    input  logic                send_pkt_enqueue_rdy,
    output logic                app_flow_notif_val,
    input  logic                app_flow_notif_rdy,
    output logic                app_flow_notif_close,
    output logic [FLOWID_W-1:0] cur_flowid,
    output logic                slow_path_done_val,
    input  logic                slow_path_done_rdy,
    output logic                done_drop,
    output logic [1:0]          done_reason,
    output logic [CNT_W-1:0]    stat_open_cnt,
    output logic [CNT_W-1:0]    stat_close_cnt,
    output logic [CNT_W-1:0]    stat_drop_cnt
);

    localparam int unsigned TMR_MAX = (FLOWID_WAIT > HS_TIMEOUT) ? FLOWID_WAIT : HS_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    logic [ST_W-1:0]     state_q, state_nxt;
    reason_e             reason_q, reason_nxt;
    logic                close_nxt;
    logic [FLOWID_W-1:0] flowid_nxt;
    logic                tmr_load_c;
    logic [TMR_W-1:0]    tmr_load_val_c;
    logic                tmr_expired_c;
    logic                stat_evt_c;

    // Counter restarts on every state change with the limit of the state being entered
    assign tmr_load_c     = (state_nxt != state_q);
    assign tmr_load_val_c = (state_nxt == ST_ALLOC) ? TMR_W'(FLOWID_WAIT - 1)
                                                    : TMR_W'(HS_TIMEOUT - 1);

    tcp_slow_hs_timer #(.W(TMR_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load_c),
        .load_val  (tmr_load_val_c),
        .expired_c (tmr_expired_c)
    );

    // Next-state and next-value decode
    always_comb begin
        state_nxt  = state_q;
        reason_nxt = reason_q;
        close_nxt  = app_flow_notif_close;
        flowid_nxt = cur_flowid;
        case (state_q)
            ST_IDLE: begin
                if (slow_path_val && slow_path_rdy) begin
                    reason_nxt = RSN_OK;
                    close_nxt  = 1'b0;
                    if (slow_path_flags == FLAG_SYN && !slow_path_lookup_hit) begin
                        state_nxt = ST_ALLOC;
                    end else if (is_close_flags(slow_path_flags) && slow_path_lookup_hit) begin
                        flowid_nxt = slow_path_lookup_flowid;
                        close_nxt  = 1'b1;
                        state_nxt  = ST_NOTIF;
                    end else begin
                        reason_nxt = RSN_BAD_PKT;
                        state_nxt  = ST_DONE;
                    end
                end
            end
            ST_ALLOC: begin
                if (flowid_alloc_rdy) begin
                    flowid_nxt = flowid_alloc_id;
                    state_nxt  = ST_INIT;
                end else if (tmr_expired_c) begin
                    reason_nxt = RSN_NO_FLOWID;
                    state_nxt  = ST_DONE;
                end
            end
            ST_INIT: begin
                if (init_state_rdy) begin
                    state_nxt = ST_SEND;
                end else if (tmr_expired_c) begin
                    reason_nxt = RSN_TIMEOUT;
                    state_nxt  = ST_FREE;
                end
            end
            ST_SEND: begin
                if (send_pkt_enqueue_rdy) begin
                    close_nxt = 1'b0;
                    state_nxt = ST_NOTIF;
                end else if (tmr_expired_c) begin
                    reason_nxt = RSN_TIMEOUT;
                    state_nxt  = ST_FREE;
                end
            end
            ST_NOTIF: begin
                if (app_flow_notif_rdy) begin
                    state_nxt = app_flow_notif_close ? ST_FREE : ST_DONE;
                end else if (tmr_expired_c) begin
                    reason_nxt = RSN_TIMEOUT;
                    state_nxt  = ST_FREE;
                end
            end
            ST_FREE: begin
                if (flowid_free_rdy) begin
                    state_nxt = ST_DONE;
                end else if (tmr_expired_c) begin
                    reason_nxt = RSN_TIMEOUT;
                    state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (slow_path_done_rdy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= ST_IDLE;
            reason_q             <= RSN_OK;
            app_flow_notif_close <= 1'b0;
            cur_flowid           <= '0;
            slow_path_rdy        <= 1'b0;
            flowid_alloc_val     <= 1'b0;
            init_state_val       <= 1'b0;
            send_pkt_enqueue_val <= 1'b0;
            app_flow_notif_val   <= 1'b0;
            flowid_free_val      <= 1'b0;
            slow_path_done_val   <= 1'b0;
            done_drop            <= 1'b0;
        end else begin
            state_q              <= state_nxt;
            reason_q             <= reason_nxt;
            app_flow_notif_close <= close_nxt;
            cur_flowid           <= flowid_nxt;
            slow_path_rdy        <= (state_nxt == ST_IDLE);
            flowid_alloc_val     <= (state_nxt == ST_ALLOC);
            init_state_val       <= (state_nxt == ST_INIT);
            send_pkt_enqueue_val <= (state_nxt == ST_SEND);
            app_flow_notif_val   <= (state_nxt == ST_NOTIF);
            flowid_free_val      <= (state_nxt == ST_FREE);
            slow_path_done_val   <= (state_nxt == ST_DONE);
            done_drop            <= (state_nxt == ST_DONE) && (reason_nxt != RSN_OK);
        end
    end

    assign done_reason = reason_q;
    assign stat_evt_c  = (state_q == ST_DONE) && slow_path_done_rdy;

    // Saturating outcome counters, bumped as each completion is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_open_cnt  <= '0;
            stat_close_cnt <= '0;
            stat_drop_cnt  <= '0;
        end else if (stat_evt_c) begin
            if (reason_q != RSN_OK) begin
                if (stat_drop_cnt != '1) stat_drop_cnt <= stat_drop_cnt + CNT_W'(1);
            end else if (app_flow_notif_close) begin
                if (stat_close_cnt != '1) stat_close_cnt <= stat_close_cnt + CNT_W'(1);
            end else begin
                if (stat_open_cnt != '1) stat_open_cnt <= stat_open_cnt + CNT_W'(1);
            end
        end
    end

endmodule
